sram_config_loader: RTL and testbench



---
 rtl/cfg_loader_pkg.sv | 28 ++
 rtl/row_decoder.sv | 21 ++
 rtl/sram_config_loader.sv | 186 ++++++++++++++++++
 tb/tb_sram_config_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared types and helpers for the SRAM configuration loader: FSM state
// encoding, default timing constants and a clog2 helper with a floor of 1.
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WRITE,
    HOLD,
    READ,
    CHECK
  } state_e;

  localparam int DefaultRows        = 16;
  localparam int DefaultCols        = 32;
  localparam int DefaultWriteCycles = 2;
  localparam int DefaultReadCycles  = 2;
  localparam int DefaultVerify      = 1;

  // A single-row array still needs a one-bit index, hence the floor of 1.
  function automatic int clog2Min1(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/row_decoder.sv
// Row index to one-hot word-line vector plus its complement. The enable
// forces every line low (complement all ones) when the line group is idle.
module row_decoder #(
  parameter int ROWS  = 16,
  parameter int ROW_W = 4
) (
  input  logic [ROW_W-1:0] row_i,
  input  logic             en_i,
  output logic [ROWS-1:0]  line_o,
  output logic [ROWS-1:0]  lineN_o
);

  always_comb begin
    line_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      line_o[r] = en_i && (row_i == ROW_W'(r));
    end
    lineN_o = ~line_o;
  end

endmodule

// File: rtl/sram_config_loader.sv
// Row-by-row write/readback controller for the fabric's SRAM config cells.
// Every output is registered from next-state values so word lines never glitch.
module sram_config_loader
  import cfg_loader_pkg::*;
#(
  parameter int ROWS         = DefaultRows,
  parameter int COLS         = DefaultCols,
  parameter int WRITE_CYCLES = DefaultWriteCycles,
  parameter int READ_CYCLES  = DefaultReadCycles,
  parameter int VERIFY       = DefaultVerify
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          io_start,
  input  logic                          io_cfgValid,
  output logic                          io_cfgReady,
  input  logic [COLS-1:0]               io_cfgData,
  output logic [ROWS-1:0]               io_write,
  output logic [ROWS-1:0]               io_writeN,
  output logic [ROWS-1:0]               io_read,
  output logic [ROWS-1:0]               io_readN,
  output logic [COLS-1:0]               io_bitWrite,
  output logic                          io_bitWriteEn,
  input  logic [COLS-1:0]               io_bitRead,
  output logic                          io_busy,
  output logic                          io_done,
  output logic                          io_error,
  output logic [clog2Min1(ROWS)-1:0]    io_errRow
);

  localparam int RowW      = clog2Min1(ROWS);
  localparam int MaxCycles = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int CntW      = clog2Min1(MaxCycles);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [COLS-1:0]   bitWrite_q, bitWrite_d;
  logic [COLS-1:0]   sample_q, sample_d;
  logic              bitWriteEn_q, bitWriteEn_d;
  logic              cfgReady_q, cfgReady_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [RowW-1:0]   errRow_q, errRow_d;
  logic [ROWS-1:0]   write_q, writeN_q, read_q, readN_q;
  logic [ROWS-1:0]   wrLine, wrLineN, rdLine, rdLineN;
  logic              handshake, rowDone, lastRow;

  assign handshake = (state_q == WAIT_DATA) && io_cfgValid && cfgReady_q;
  assign lastRow   = (row_q == RowW'(ROWS - 1));
  // Without readback the row finishes straight out of HOLD.
  assign rowDone   = (state_q == CHECK) || ((state_q == HOLD) && (VERIFY == 0));

  row_decoder #(.ROWS(ROWS), .ROW_W(RowW)) writeDecoder (
    .row_i   (row_q),
    .en_i    (state_d == WRITE),
    .line_o  (wrLine),
    .lineN_o (wrLineN)
  );

  row_decoder #(.ROWS(ROWS), .ROW_W(RowW)) readDecoder (
    .row_i   (row_q),
    .en_i    (state_d == READ),
    .line_o  (rdLine),
    .lineN_o (rdLineN)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      bitWrite_q   <= '0;
      sample_q     <= '0;
      bitWriteEn_q <= 1'b0;
      cfgReady_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      errRow_q     <= '0;
      write_q      <= '0;
      writeN_q     <= '1;
      read_q       <= '0;
      readN_q      <= '1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      bitWrite_q   <= bitWrite_d;
      sample_q     <= sample_d;
      bitWriteEn_q <= bitWriteEn_d;
      cfgReady_q   <= cfgReady_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      errRow_q     <= errRow_d;
      write_q      <= wrLine;
      writeN_q     <= wrLineN;
      read_q       <= rdLine;
      readN_q      <= rdLineN;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d = WAIT_DATA;
          row_d   = '0;
        end
      end
      WAIT_DATA: begin
        if (handshake) begin
          state_d = WRITE;
          cnt_d   = '0;
        end
      end
      WRITE: begin
        if (cnt_q == CntW'(WRITE_CYCLES - 1)) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (VERIFY != 0) begin
          state_d = READ;
          cnt_d   = '0;
        end
      end
      READ: begin
        if (cnt_q == CntW'(READ_CYCLES - 1)) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (rowDone) begin
      if (lastRow) begin
        state_d = IDLE;
      end else begin
        state_d = WAIT_DATA;
        row_d   = row_q + 1'b1;
      end
    end
  end

  // Only the first mismatching row is recorded until the next accepted start.
  always_comb begin
    cfgReady_d   = (state_d == WAIT_DATA);
    busy_d       = (state_d != IDLE);
    bitWriteEn_d = (state_d == WRITE) || (state_d == HOLD);
    done_d       = rowDone && lastRow;
    bitWrite_d   = handshake ? io_cfgData : bitWrite_q;
    sample_d     = ((state_q == READ) && (state_d == CHECK)) ? io_bitRead : sample_q;
    error_d      = error_q;
    errRow_d     = errRow_q;
    if ((state_q == IDLE) && io_start) begin
      error_d  = 1'b0;
      errRow_d = '0;
    end else if ((state_q == CHECK) && (sample_q != bitWrite_q) && !error_q) begin
      error_d  = 1'b1;
      errRow_d = row_q;
    end
  end

  assign io_cfgReady   = cfgReady_q;
  assign io_write      = write_q;
  assign io_writeN     = writeN_q;
  assign io_read       = read_q;
  assign io_readN      = readN_q;
  assign io_bitWrite   = bitWrite_q;
  assign io_bitWriteEn = bitWriteEn_q;
  assign io_busy       = busy_q;
  assign io_done       = done_q;
  assign io_error      = error_q;
  assign io_errRow     = errRow_q;

endmodule

// File: tb/tb_sram_config_loader.sv
// Bench for sram_config_loader: a verifying and a non-verifying instance
// driven against a behavioural cell array and row-timing expectations.
module tb_sram_config_loader;

  localparam int ROWS  = 4;
  localparam int COLS  = 8;
  localparam int WC    = 2;
  localparam int RC    = 2;
  localparam int STALL = 10;

  logic clock, reset;
  logic start, valid, startN, validN;
  logic [COLS-1:0] data, dataN, bitRead, bitReadN;
  logic ready, readyN, bitWriteEn, bitWriteEnN;
  logic busy, busyN, done, doneN, error, errorN;
  logic [ROWS-1:0] write, writeN, read, readN;
  logic [ROWS-1:0] nWrite, nWriteN, nRead, nReadN;
  logic [COLS-1:0] bitWrite, bitWriteNv;
  logic [1:0] errRow, errRowN;

  int checks, errors, cyc;
  int clearReq, clearSeen, clearSeenN;
  logic [COLS-1:0] words [ROWS];
  logic [COLS-1:0] mem [ROWS];
  bit corrupt [ROWS];

  int wrStart [ROWS], wrLen [ROWS];
  logic [COLS-1:0] wrData [ROWS];
  int wrEvents, rdCycles, doneCnt, doneCyc, invBad;
  logic [ROWS-1:0] prevWrite;

  int nStart [ROWS], nLen [ROWS];
  logic [COLS-1:0] nData [ROWS];
  int nEvents, nReadCycles, nDone, nDoneCyc, nInvBad;
  logic [ROWS-1:0] prevWriteN;

  sram_config_loader #(.ROWS(ROWS), .COLS(COLS), .WRITE_CYCLES(WC), .READ_CYCLES(RC), .VERIFY(1)) dut (
    .clock(clock), .reset(reset), .io_start(start), .io_cfgValid(valid), .io_cfgReady(ready),
    .io_cfgData(data), .io_write(write), .io_writeN(writeN), .io_read(read), .io_readN(readN),
    .io_bitWrite(bitWrite), .io_bitWriteEn(bitWriteEn), .io_bitRead(bitRead), .io_busy(busy),
    .io_done(done), .io_error(error), .io_errRow(errRow)
  );

  sram_config_loader #(.ROWS(ROWS), .COLS(COLS), .WRITE_CYCLES(WC), .READ_CYCLES(RC), .VERIFY(0)) dutN (
    .clock(clock), .reset(reset), .io_start(startN), .io_cfgValid(validN), .io_cfgReady(readyN),
    .io_cfgData(dataN), .io_write(nWrite), .io_writeN(nWriteN), .io_read(nRead), .io_readN(nReadN),
    .io_bitWrite(bitWriteNv), .io_bitWriteEn(bitWriteEnN), .io_bitRead(bitReadN), .io_busy(busyN),
    .io_done(doneN), .io_error(errorN), .io_errRow(errRowN)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  function automatic int oneHotIdx(input logic [ROWS-1:0] v);
    for (int i = 0; i < ROWS; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Cell array: the selected row drives the read bus, optionally with bit 0 flipped.
  always_comb begin
    bitRead = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (read[r]) bitRead = mem[r] ^ {{(COLS-1){1'b0}}, corrupt[r]};
    end
  end

  always @(negedge clock) begin
    int r;
    if (clearReq != clearSeen) begin
      clearSeen = clearReq;
      wrEvents = 0; rdCycles = 0; doneCnt = 0; doneCyc = 0; invBad = 0;
      for (int i = 0; i < ROWS; i++) begin wrStart[i] = -100; wrLen[i] = 0; wrData[i] = '0; end
    end
    if (writeN !== ~write || readN !== ~read) invBad++;
    if (write != 0 && read != 0) invBad++;
    if ($countones(write) > 1 || $countones(read) > 1) invBad++;
    if (write != 0) begin
      r = oneHotIdx(write);
      if (!bitWriteEn) invBad++;
      if (prevWrite == 0) begin
        wrEvents++; wrStart[r] = cyc; wrData[r] = bitWrite; wrLen[r] = 0;
      end
      wrLen[r]++;
      mem[r] = bitWrite;
    end
    if (read != 0) rdCycles++;
    if (done) begin doneCnt++; doneCyc = cyc; end
    prevWrite = write;
  end

  always @(negedge clock) begin
    int r;
    if (clearReq != clearSeenN) begin
      clearSeenN = clearReq;
      nEvents = 0; nReadCycles = 0; nDone = 0; nDoneCyc = 0; nInvBad = 0;
      for (int i = 0; i < ROWS; i++) begin nStart[i] = -100; nLen[i] = 0; nData[i] = '0; end
    end
    if (nWriteN !== ~nWrite || nReadN !== ~nRead || $countones(nWrite) > 1) nInvBad++;
    if (nWrite != 0) begin
      r = oneHotIdx(nWrite);
      if (prevWriteN == 0) begin
        nEvents++; nStart[r] = cyc; nData[r] = bitWriteNv; nLen[r] = 0;
      end
      nLen[r]++;
    end
    if (nRead != 0) nReadCycles++;
    if (doneN) begin nDone++; nDoneCyc = cyc; end
    prevWriteN = nWrite;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input bit sel);
    int n;
    n = 0;
    while (!(sel ? readyN : ready) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) checkOutput("readyTimeout", 32'(n), 32'(0));
  endtask

  // One full-array load; stallRow/startRow/resetRow inject events after that row (-1 = none).
  task automatic applyStimulus(input bit sel, input int stallRow, input int startRow, input int resetRow);
    int n, stallBad;
    clearReq++;
    repeat (2) @(negedge clock);
    if (sel) startN = 1'b1; else start = 1'b1;
    @(negedge clock);
    start = 1'b0; startN = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (sel) begin dataN = words[r]; validN = 1'b1; end
      else begin data = words[r]; valid = (r != stallRow); end
      waitReady(sel);
      if (r == stallRow) begin
        stallBad = 0;
        for (int i = 0; i < STALL; i++) begin
          if (!(ready && write == 0 && read == 0)) stallBad++;
          @(negedge clock);
        end
        checkOutput("stallReadyLines", 32'(stallBad), 32'(0));
        valid = 1'b1;
      end
      @(negedge clock);
      if (r == startRow) begin
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
      end
      if (r == resetRow) begin
        checkOutput("preResetWrite", 32'(write), 32'(1 << r));
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        valid = 1'b0;
        checkOutput("resetWrite", 32'(write), 32'(0));
        checkOutput("resetWriteN", 32'(writeN), 32'(4'hF));
        checkOutput("resetBitWriteEn", 32'(bitWriteEn), 32'(0));
        checkOutput("resetBusy", 32'(busy), 32'(0));
        return;
      end
    end
    valid = 1'b0; validN = 1'b0;
    n = 0;
    while ((sel ? nDone : doneCnt) == 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) checkOutput("doneTimeout", 32'(n), 32'(0));
    repeat (5) @(negedge clock);
  endtask

  task automatic checkLoadV(input int stallRow);
    int expErr, expRow;
    expErr = 0; expRow = 0;
    for (int r = ROWS - 1; r >= 0; r--) if (corrupt[r]) begin expErr = 1; expRow = r; end
    checkOutput("rowsWritten", 32'(wrEvents), 32'(ROWS));
    for (int r = 0; r < ROWS; r++) begin
      checkOutput($sformatf("row%0dData", r), 32'(wrData[r]), 32'(words[r]));
      checkOutput($sformatf("row%0dWriteLen", r), 32'(wrLen[r]), 32'(WC));
      if (r > 0)
        checkOutput($sformatf("row%0dSpacing", r), 32'(wrStart[r] - wrStart[r-1]),
                    32'(1 + WC + 1 + RC + 1 + ((r == stallRow) ? STALL : 0)));
    end
    checkOutput("readCycles", 32'(rdCycles), 32'(ROWS * RC));
    checkOutput("doneCount", 32'(doneCnt), 32'(1));
    checkOutput("doneLatency", 32'(doneCyc - wrStart[ROWS-1]), 32'(WC + 1 + RC + 1));
    checkOutput("errorAfterDone", 32'(error), 32'(expErr));
    checkOutput("errRow", 32'(errRow), 32'(expRow));
    checkOutput("invariants", 32'(invBad), 32'(0));
    checkOutput("idleBusy", 32'(busy), 32'(0));
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; clearReq = 0; clearSeen = 0; clearSeenN = 0;
    start = 0; valid = 0; data = '0; startN = 0; validN = 0; dataN = '0; bitReadN = '0;
    for (int r = 0; r < ROWS; r++) begin mem[r] = '0; corrupt[r] = 1'b0; end
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    $display("[TB] reset values");
    checkOutput("rstWrite", 32'(write), 32'(0));
    checkOutput("rstWriteN", 32'(writeN), 32'(4'hF));
    checkOutput("rstRead", 32'(read), 32'(0));
    checkOutput("rstReadN", 32'(readN), 32'(4'hF));
    checkOutput("rstBitWrite", 32'(bitWrite), 32'(0));
    checkOutput("rstBitWriteEn", 32'(bitWriteEn), 32'(0));
    checkOutput("rstReady", 32'(ready), 32'(0));
    checkOutput("rstBusy", 32'(busy), 32'(0));
    checkOutput("rstDone", 32'(done), 32'(0));
    checkOutput("rstError", 32'({error, errRow}), 32'(0));
    checkOutput("rstNWriteN", 32'(nWriteN), 32'(4'hF));

    $display("[TB] full load with fixed words");
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00;
    applyStimulus(1'b0, -1, -1, -1);
    checkLoadV(-1);

    $display("[TB] corrupted readback on rows 2 and 3");
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    corrupt[2] = 1'b1; corrupt[3] = 1'b1;
    applyStimulus(1'b0, -1, -1, -1);
    checkLoadV(-1);
    corrupt[2] = 1'b0; corrupt[3] = 1'b0;

    $display("[TB] backpressure before row 1");
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    applyStimulus(1'b0, 1, -1, -1);
    checkLoadV(1);

    $display("[TB] start pulse while busy");
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    applyStimulus(1'b0, -1, 1, -1);
    checkLoadV(-1);

    $display("[TB] reset during row 1 write");
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    applyStimulus(1'b0, -1, -1, 1);
    repeat (15) @(negedge clock);
    checkOutput("noDoneAfterReset", 32'(doneCnt), 32'(0));
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    applyStimulus(1'b0, -1, -1, -1);
    checkLoadV(-1);

    $display("[TB] readback disabled");
    for (int r = 0; r < ROWS; r++) words[r] = COLS'($urandom);
    applyStimulus(1'b1, -1, -1, -1);
    checkOutput("nRowsWritten", 32'(nEvents), 32'(ROWS));
    for (int r = 0; r < ROWS; r++) begin
      checkOutput($sformatf("nRow%0dData", r), 32'(nData[r]), 32'(words[r]));
      checkOutput($sformatf("nRow%0dWriteLen", r), 32'(nLen[r]), 32'(WC));
      if (r > 0)
        checkOutput($sformatf("nRow%0dSpacing", r), 32'(nStart[r] - nStart[r-1]), 32'(1 + WC + 1));
    end
    checkOutput("nReadCycles", 32'(nReadCycles), 32'(0));
    checkOutput("nDoneCount", 32'(nDone), 32'(1));
    checkOutput("nDoneLatency", 32'(nDoneCyc - nStart[ROWS-1]), 32'(WC + 1));
    checkOutput("nError", 32'(errorN), 32'(0));
    checkOutput("nInvariants", 32'(nInvBad), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
